fifo_umbral: RTL and testbench
==============================

# fifo_umbral

Parameterised synchronous FIFO with programmable almost-full/almost-empty thresholds. It is the consumer end of the threshold interface driven by the control state machine (`UMF_OUT`/`UVC_OUT`/`UD_OUT`) and the producer of the status bits that the state machine reads (`FIFO_EMPTY`, `FIFO_ERROR`). One instance per queue: main FIFO, virtual channels and destination FIFOs. Each instance contributes one bit to each 5-bit status bus.

## Interface
- `DATA_WIDTH`, 10: payload width in bits.
- `ADDR_WIDTH`, 3: pointer width; depth = 2^ADDR_WIDTH (default 8 entries).
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately.
- `init` input 1: synchronous soft clear, same effect as reset, taken on the next rising edge.
- `wr_en` input 1: push request.
- `data_in` input DATA_WIDTH: push data, sampled when `wr_en` is high.
- `rd_en` input 1: pop request.
- `umbral_alto` input 8: almost-full threshold in entries.
- `umbral_bajo` input 8: almost-empty threshold in entries.
- `data_out` output DATA_WIDTH: registered pop data.
- `valid_out` output 1: `data_out` holds a newly popped word this cycle.
- `count` output ADDR_WIDTH+1: current occupancy, 0..2^ADDR_WIDTH.
- `fifo_empty` output 1: count == 0.
- `fifo_full` output 1: count == 2^ADDR_WIDTH.
- `almost_full` output 1: count >= umbral_alto.
- `almost_empty` output 1: count <= umbral_bajo.
- `fifo_error` output 1: overflow or underflow indication.

## Operation
- **Storage.** 2^ADDR_WIDTH × DATA_WIDTH register array. Write pointer and read pointer are each ADDR_WIDTH bits and wrap modulo depth with no special casing. `count` is a separate register.
- **Push.** With `wr_en` high and not full, write `data_in` at the write pointer, then increment the write pointer.
- **Pop.** With `rd_en` high and not empty, register `mem[rd_ptr]` into `data_out`, then increment the read pointer. `valid_out` is 1 for exactly that cycle.
- **Simultaneous push and pop:**
  - Not empty and not full: both happen and `count` is unchanged.
  - Full: both happen, because the pop frees the slot. No error and `count` is unchanged.
  - Empty: only the push happens. The pop is an underflow, so `fifo_error` asserts and `count` becomes 1. There is no read-through.
- **Overflow.** `wr_en` while full with no pop: data is dropped, pointers and `count` hold, `fifo_error` asserts.
- **Underflow.** `rd_en` while empty: `data_out` holds, `valid_out` is 0, `fifo_error` asserts.
- **Thresholds.** Compare the zero-extended `count` against `umbral_alto`/`umbral_bajo`. Thresholds may change at any time and take effect in the same cycle.
  - `umbral_alto` = 0 forces `almost_full` to 1.
  - `umbral_bajo` >= depth forces `almost_empty` to 1.
- **No handshake back-pressure.** The upstream controller must use `fifo_full`/`almost_full`.

## Timing
- **Reset values.** When `reset` is low, or on the edge following `init` high:
  - pointers, `count`, `data_out`, `valid_out` and `fifo_error` are 0;
  - `fifo_empty` = 1, `fifo_full` = 0;
  - `almost_full` and `almost_empty` follow their comparisons with `count` = 0.
- **Memory contents** are not cleared.
- **Priority.** `init` has priority over `wr_en`/`rd_en` in the same cycle: both requests are ignored.
- **Read latency.** 1 cycle: `rd_en` in cycle N gives `data_out`/`valid_out` in cycle N+1.
- **Write-to-read latency.** A word pushed in cycle N can be popped with `rd_en` in cycle N+1, and appears on `data_out` in N+2.
- **Flag timing.** Status flags are combinational from registered `count` (plus the threshold inputs). They reflect a push or pop on the edge after the request.
- **Error timing.** `fifo_error` is registered and rises on the edge after the offending request.
- **Reset mid-operation.** An asynchronous assertion of `reset` discards stored data. Outputs go to their reset values without waiting for a clock edge.

## Configuration
- **`FIFO_ERROR_STICKY_EN` defined:** `fifo_error` latches high on the first overflow or underflow. It clears only on `reset` low or `init`.
- **`FIFO_ERROR_STICKY_EN` undefined:** `fifo_error` is a one-cycle pulse for each offending cycle. Consecutive offending cycles keep it high.
- Data-path behaviour is identical in both builds.

## Test plan
- **Reset.** Hold `reset` low, then release → `count`=0, `fifo_empty`=1, `fifo_full`=0, `fifo_error`=0, `valid_out`=0.
- **Fill, drain, wrap.** Push 8 words 0x001..0x008 → `fifo_full`=1, `count`=8. Pop 8 → `data_out` is 0x001..0x008 in order, each one cycle after its `rd_en`, then `fifo_empty`=1. Repeat 12 push/pop pairs to exercise pointer wrap with no corruption.
- **Thresholds.** `umbral_alto`=6, `umbral_bajo`=2:
  - pushes 1..8 → `almost_empty` high for `count` ≤ 2, `almost_full` high for `count` ≥ 6;
  - change `umbral_alto` to 8 at `count`=7 → `almost_full` drops the same cycle.
- **Overflow.** Full FIFO plus `wr_en` of 0x3FF → `count` stays 8, `fifo_error`=1 the next cycle, and 0x3FF never appears on readout. Sticky build: `fifo_error` stays high after the FIFO drains. Non-sticky build: `fifo_error` is a one-cycle pulse.
- **Simultaneous events:**
  - full with `wr_en`+`rd_en` → `count`=8, no error;
  - empty with `wr_en`+`rd_en` → `count`=1, `valid_out`=0, `fifo_error` asserts.
- **Init and reset mid-operation.** With `count`=5, pulse `init` together with `wr_en` → `count`=0 next edge and the push is ignored. With `count`=3, assert `reset` asynchronously between edges → outputs clear immediately.

Source files
------------

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-full / almost-empty thresholds.
// Define FIFO_ERROR_STICKY_EN to latch fifo_error_o until reset or init.
module fifo_umbral #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  init_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  input  logic                  rd_en_i,
  input  logic [7:0]            umbral_alto_i,
  input  logic [7:0]            umbral_bajo_i,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  valid_out_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  fifo_empty_o,
  output logic                  fifo_full_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  fifo_error_o
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;

  logic empty, full, do_push, do_pop, err_evt;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(Depth));

  // A pop on a full FIFO frees the slot, so a simultaneous push is accepted.
  assign do_push = ~init_i & wr_en_i & (~full | rd_en_i);
  assign do_pop  = ~init_i & rd_en_i & ~empty;
  assign err_evt = ~init_i & ((wr_en_i & full & ~rd_en_i) | (rd_en_i & empty));

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = do_pop;
    if (init_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      data_out_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (do_pop) begin
        rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
        data_out_d = mem_q[rd_ptr_q];
      end
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    error_d = 1'b0;
    if (!init_i) begin
`ifdef FIFO_ERROR_STICKY_EN
      error_d = error_q | err_evt;
`else
      error_d = err_evt;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  // Storage is deliberately not reset; the pointers define what is live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_in_i;
  end

  assign data_out_o     = data_out_q;
  assign valid_out_o    = valid_q;
  assign count_o        = count_q;
  assign fifo_empty_o   = empty;
  assign fifo_full_o    = full;
  assign almost_full_o  = 32'(count_q) >= 32'(umbral_alto_i);
  assign almost_empty_o = 32'(count_q) <= 32'(umbral_bajo_i);
  assign fifo_error_o   = error_q;

endmodule

// File: tb/tb_fifo_umbral.sv
// Scoreboard bench for fifo_umbral: queue-based reference model, decoupled data monitor.
module tb_fifo_umbral;

  localparam int Depth = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [9:0] din = '0;
  logic [7:0] alto = 8'd6, bajo = 8'd2;
  logic [9:0] dout;
  logic       valid, empty, full, af, ae, err;
  logic [3:0] count;

  int checks = 0, failures = 0;

  // Reference model state
  logic [9:0] mq[$];
  logic [9:0] exp_q[$];
  bit         m_valid = 0, m_err = 0;

  fifo_umbral #(.DATA_WIDTH(10), .ADDR_WIDTH(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .init_i(init), .wr_en_i(wr), .data_in_i(din), .rd_en_i(rd),
    .umbral_alto_i(alto), .umbral_bajo_i(bajo), .data_out_o(dout), .valid_out_o(valid),
    .count_o(count), .fifo_empty_o(empty), .fifo_full_o(full), .almost_full_o(af),
    .almost_empty_o(ae), .fifo_error_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: flags every cycle, data whenever the DUT presents a popped word.
  always @(negedge clk) begin
    chk("count", int'(count), mq.size());
    chk("fifo_empty", int'(empty), int'(mq.size() == 0));
    chk("fifo_full", int'(full), int'(mq.size() == Depth));
    chk("almost_full", int'(af), int'(mq.size() >= int'(alto)));
    chk("almost_empty", int'(ae), int'(mq.size() <= int'(bajo)));
    chk("fifo_error", int'(err), int'(m_err));
    chk("valid_out", int'(valid), int'(m_valid));
    if (valid) begin
      if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
      else chk("data_out", int'(dout), int'(exp_q.pop_front()));
    end
  end

  task automatic model_reset();
    mq.delete();
    m_valid = 0;
    m_err = 0;
  endtask

  // Drive one cycle of requests and advance the model on the same edge.
  task automatic step(input bit w, input logic [9:0] d, input bit r, input bit i);
    bit is_full, is_empty, evt;
    wr = w; din = d; rd = r; init = i;
    @(posedge clk);
    is_full = (mq.size() == Depth);
    is_empty = (mq.size() == 0);
    if (i) begin
      model_reset();
    end else begin
      evt = (w && is_full && !r) || (r && is_empty);
      m_valid = r && !is_empty;
      if (m_valid) exp_q.push_back(mq.pop_front());
      if (w && (!is_full || r)) mq.push_back(d);
`ifdef FIFO_ERROR_STICKY_EN
      m_err = m_err | evt;
`else
      m_err = evt;
`endif
    end
    #1;
    wr = 0; rd = 0; init = 0;
  endtask

  function automatic logic [9:0] rnd_data();
    return 10'($urandom_range(0, 10'h3FE));
  endfunction

  initial begin
    #23 rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill with 1..8 under thresholds 6/2, lower almost_full at count 7.
    for (int k = 1; k <= 7; k++) step(1, 10'(k), 0, 0);
    alto = 8'd8;
    #1 chk("af_threshold_change", int'(af), 0);
    step(1, 10'd8, 0, 0);
    alto = 8'd6;
    // Overflow with 0x3FF, then simultaneous push/pop while full.
    step(1, 10'h3FF, 0, 0);
    step(0, '0, 0, 0);
    step(1, 10'd9, 1, 0);
    for (int k = 0; k < 8; k++) step(0, '0, 1, 0);
    step(0, '0, 0, 0);
    // Underflow together with a push on empty: push only, error raised.
    step(1, 10'h055, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    // Wrap: 12 push/pop pairs.
    for (int k = 0; k < 12; k++) begin
      step(1, 10'(10'h100 + k), 0, 0);
      step(0, '0, 1, 0);
    end

    // init with push at count 5.
    for (int k = 0; k < 5; k++) step(1, rnd_data(), 0, 0);
    step(1, 10'h0AA, 0, 1);
    step(0, '0, 1, 0);

    // Async reset mid-operation at count 3.
    for (int k = 0; k < 3; k++) step(1, rnd_data(), 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_empty", int'(empty), 1);
    chk("async_valid", int'(valid), 0);
    model_reset();
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;

    // Randomised traffic with changing thresholds.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        alto = 8'($urandom_range(0, 10));
        bajo = 8'($urandom_range(0, 10));
      end
      step(bit'($urandom_range(0, 1)), rnd_data(), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 63) == 0));
    end
    step(0, '0, 0, 0);
    @(negedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
